// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings, symbol constants and the BBCBC frame for pattern_gen and its detector
package seq_pkg;
  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    S_B1  = 7'b0000010,
    S_B2  = 7'b0000100,
    S_C1  = 7'b0001000,
    S_B3  = 7'b0010000,
    S_C2  = 7'b0100000,
    S_GAP = 7'b1000000
  } state_t;
  localparam logic SYM_B = 1'b0;
  localparam logic SYM_C = 1'b1;
  localparam logic [4:0] FRAME = {SYM_B, SYM_B, SYM_C, SYM_B, SYM_C};
  function automatic logic sym_of(input state_t s);
    return s == S_B1 ? FRAME[4] : s == S_B2 ? FRAME[3] : s == S_C1 ? FRAME[2] :
           s == S_B3 ? FRAME[1] : s == S_C2 ? FRAME[0] : SYM_C;
  endfunction
  function automatic logic is_sym(input state_t s);
    return s inside {S_B1, S_B2, S_C1, S_B3, S_C2};
  endfunction
endpackage

// File: rtl/pattern_gen_cnt.sv
// pattern_gen_cnt: frame and gap down-counters with load, saturating decrement and zero flags
module pattern_gen_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_load,
  input  logic [3:0] f_val,
  input  logic       f_dec,
  input  logic       g_load,
  input  logic [2:0] g_val,
  input  logic       g_dec,
  output logic       f_zero,
  output logic       g_zero
);
  logic [3:0] f_cnt;
  logic [2:0] g_cnt;
  assign f_zero = f_cnt == 4'd0;
  assign g_zero = g_cnt == 3'd0;
  // load wins over decrement; decrement stops at zero so counts never wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f_cnt <= '0;
      g_cnt <= '0;
    end else begin
      if (f_load) f_cnt <= f_val;
      else if (f_dec && !f_zero) f_cnt <= f_cnt - 4'd1;
      if (g_load) g_cnt <= g_val;
      else if (g_dec && !g_zero) g_cnt <= g_cnt - 3'd1;
    end
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: serial BBCBC frame generator with stall, inter-frame gap and optional abort (PATTERN_GEN_ABORT_EN)
module pattern_gen
  import seq_pkg::*;
#(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] frames,
  input  logic       hold,
`ifdef PATTERN_GEN_ABORT_EN
  input  logic       abort,
`endif
  output logic       d,
  output logic       dv,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] GAP_LD = 3'(GAP == 0 ? 0 : GAP - 1);
  state_t state, nxt;
  logic f_load, f_dec, g_load, g_dec, f_zero, g_zero, ab;
`ifdef PATTERN_GEN_ABORT_EN
  assign ab = abort && state != IDLE;
`else
  assign ab = 1'b0;
`endif
  // frame counter holds frames remaining after the current one, so zero marks the last frame
  pattern_gen_cnt u_cnt (
    .clk(clk), .rst(rst),
    .f_load(f_load), .f_val(frames - 4'd1), .f_dec(f_dec),
    .g_load(g_load), .g_val(GAP_LD), .g_dec(g_dec),
    .f_zero(f_zero), .g_zero(g_zero)
  );
  // next state and counter controls; abort overrides hold, hold freezes everything else
  always_comb begin
    nxt = state;
    f_load = 1'b0;
    f_dec = 1'b0;
    g_load = 1'b0;
    g_dec = 1'b0;
    if (ab) nxt = IDLE;
    else if (!hold)
      case (state)
        IDLE: if (start && frames != 4'd0) begin
          nxt = S_B1;
          f_load = 1'b1;
        end
        S_B1: nxt = S_B2;
        S_B2: nxt = S_C1;
        S_C1: nxt = S_B3;
        S_B3: nxt = S_C2;
        S_C2: if (f_zero) nxt = IDLE;
        else begin
          f_dec = 1'b1;
          g_load = 1'b1;
          nxt = GAP == 0 ? S_B1 : S_GAP;
        end
        S_GAP: if (g_zero) nxt = S_B1;
        else g_dec = 1'b1;
        default: nxt = IDLE;
      endcase
  end
  // state and registered outputs; done fires on entry to the last frame's final symbol
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      d <= SYM_C;
      dv <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      d <= hold && !ab ? d : sym_of(nxt);
      dv <= !hold && is_sym(nxt);
      busy <= nxt != IDLE;
      done <= state == S_B3 && nxt == S_C2 && f_zero;
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed checks of pattern_gen (GAP=2) with a BBCBC detector loopback
module tb_pattern_gen;
  import seq_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [3:0] frames = 4'd0;
  logic d, dv, busy, done;
  int total = 0, bad = 0;
  int pd_cnt = 0, done_cnt = 0, dv_cnt = 0, nsym = 0;
  logic [4:0] sr = '0;
  always #5 clk = ~clk;
  pattern_gen #(.GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .frames(frames), .hold(hold),
`ifdef PATTERN_GEN_ABORT_EN
    .abort(abort),
`endif
    .d(d), .dv(dv), .busy(busy), .done(done)
  );
  // non-overlapping BBCBC detector plus event counters, sampled mid-cycle
  always @(negedge clk)
    if (rst) begin
      sr = '0;
      nsym = 0;
    end else begin
      if (dv) begin
        sr = {sr[3:0], d};
        if (nsym < 5) nsym = nsym + 1;
        if (nsym == 5 && sr == FRAME) begin
          pd_cnt = pd_cnt + 1;
          nsym = 0;
        end
        dv_cnt = dv_cnt + 1;
      end
      if (done) done_cnt = done_cnt + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic [3:0] n);
    start = 1'b1;
    frames = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    logic [4:0] pat;
    logic [0:7] hd, hdv, hdn;
    int pd0, dn0, dv0, pos;
    pat = 5'b00101;
    hd = 8'b00111101;
    hdv = 8'b11100011;
    hdn = 8'b00000001;
    repeat (2) @(negedge clk);
    chk("rst_d", d, 1);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    go(1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("f1_d%0d", c), d, pat[5-c]);
      chk($sformatf("f1_dv%0d", c), dv, 1);
      chk($sformatf("f1_done%0d", c), done, c == 5);
      chk($sformatf("f1_busy%0d", c), busy, 1);
      @(negedge clk);
    end
    chk("f1_busy6", busy, 0);
    chk("f1_d6", d, 1);
    chk("f1_dv6", dv, 0);
    chk("f1_done6", done, 0);
    pd0 = pd_cnt;
    dn0 = done_cnt;
    go(3);
    for (int c = 0; c < 22; c++) begin
      pos = c % 7;
      chk($sformatf("f3_d%0d", c), d, c < 19 && pos < 5 ? pat[4-pos] : 1);
      chk($sformatf("f3_dv%0d", c), dv, c < 19 && pos < 5);
      chk($sformatf("f3_done%0d", c), done, c == 18);
      @(negedge clk);
    end
    chk("f3_pd", pd_cnt - pd0, 3);
    chk("f3_done_cnt", done_cnt - dn0, 1);
    go(1);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("hold_d%0d", c), d, hd[c-1]);
      chk($sformatf("hold_dv%0d", c), dv, hdv[c-1]);
      chk($sformatf("hold_done%0d", c), done, hdn[c-1]);
      hold = c >= 3 && c <= 5;
      @(negedge clk);
    end
    chk("hold_busy9", busy, 0);
    start = 1'b1;
    frames = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("f0_busy", busy, 0);
    chk("f0_dv", dv, 0);
    chk("f0_d", d, 1);
    pd0 = pd_cnt;
    dn0 = done_cnt;
    dv0 = dv_cnt;
    go(1);
    @(negedge clk);
    start = 1'b1;
    frames = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("bz_busy3", busy, 1);
    chk("bz_d3", d, 1);
    repeat (5) @(negedge clk);
    chk("bz_busy8", busy, 0);
    chk("bz_dv_cnt", dv_cnt - dv0, 5);
    chk("bz_done_cnt", done_cnt - dn0, 1);
    chk("bz_pd", pd_cnt - pd0, 1);
    go(1);
    repeat (3) @(negedge clk);
    chk("ar_d4", d, 0);
    chk("ar_dv4", dv, 1);
    dn0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("ar_d", d, 1);
    chk("ar_dv", dv, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("ar_no_done", done_cnt - dn0, 0);
    chk("ar_idle", busy, 0);
    pd0 = pd_cnt;
    go(1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("ar2_d%0d", c), d, pat[5-c]);
      chk($sformatf("ar2_dv%0d", c), dv, 1);
      @(negedge clk);
    end
    @(negedge clk);
    chk("ar2_pd", pd_cnt - pd0, 1);
`ifdef PATTERN_GEN_ABORT_EN
    dn0 = done_cnt;
    go(4);
    repeat (8) @(negedge clk);
    chk("ab_d9", d, 0);
    chk("ab_dv9", dv, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_d", d, 1);
    chk("ab_dv", dv, 0);
    repeat (20) @(negedge clk);
    chk("ab_idle", busy, 0);
    chk("ab_no_done", done_cnt - dn0, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter GAP, default 1, number of idle cycles between consecutive frames (legal 0..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to transmit; sampled only in IDLE.
REQ-005 SHALL have port frames  input  4  number of BBCBC frames to send; latched on accepted start.
REQ-006 SHALL have port hold  input  1  stall; freezes the bit position while high.
REQ-007 SHALL have port d  output  1  serial symbol out (B=0, C=1).
REQ-008 SHALL have port dv  output  1  high when d carries a pattern symbol.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse at completion of the last frame.

Function
REQ-011 SHALL emit the frame B,B,C,B,C (00101), first symbol first, one symbol per unheld cycle, so that a non-overlapping BBCBC detector flags exactly once per frame.
REQ-012 SHALL use states IDLE, S_B1, S_B2, S_C1, S_B3, S_C2, S_GAP, one-hot encoded, all registered.
REQ-013 SHALL accept start only when in IDLE with frames!=0; start with frames==0 is ignored, and start outside IDLE is ignored.
REQ-014 SHALL drive the first symbol (d=0, dv=1) in the cycle after the accepted start edge (latency 1).
REQ-015 SHALL step S_B1->S_B2->S_C1->S_B3->S_C2 on each cycle with hold=0.
REQ-016 SHALL, from S_C2 with frames remaining, go to S_GAP for GAP cycles and then to S_B1; with GAP=0 it SHALL go directly to S_B1 (back-to-back frames).
REQ-017 SHALL, from S_C2 on the last frame, return to IDLE and assert done for exactly that one cycle.
REQ-018 SHALL, while hold=1, keep state, frame counter and gap counter unchanged, hold d at its current value and force dv=0.
REQ-019 SHALL drive d=1 (C, the idle level) and dv=0 in IDLE and S_GAP, so idle traffic never begins a false pattern.
REQ-020 SHALL keep the remaining-frame counter 4 bits wide, decremented at each S_C2 exit, never wrapping below 1.

Reset
REQ-021 SHALL on rst=1 immediately force IDLE, d=1, dv=0, busy=0, done=0, counters=0, regardless of clock.
REQ-022 SHALL on reset mid-frame abandon the frame with no done pulse; the first post-reset start SHALL begin a fresh frame at S_B1.

Configuration
REQ-023 SHALL, when PATTERN_GEN_ABORT_EN is defined, add input abort (1 bit): abort=1 in any non-IDLE state returns the FSM to IDLE on the next edge with d=1, dv=0, no done pulse, abort taking priority over hold.
REQ-024 SHALL, when PATTERN_GEN_ABORT_EN is undefined, have no abort port and run every accepted request to completion or reset.

Structure
REQ-025 SHALL take state encodings, symbol constants B/C and the 5-bit frame constant 5'b00101 from shared package seq_pkg, which the detector SHALL also use.
REQ-026 SHALL contain one sub-module, pattern_gen_cnt, holding the frame and gap down-counters with load/decrement/zero outputs.

Verification
REQ-027 Bench SHALL check: start=1, frames=1, hold=0 -> d=0,0,1,0,1 with dv=1 on cycles 1-5 after start, done=1 on cycle 5, busy low from cycle 6.
REQ-028 Bench SHALL check: frames=3, GAP=2 -> three frames separated by 2 cycles of d=1, dv=0; the detector loopback flags pd exactly 3 times; done once.
REQ-029 Bench SHALL check: hold=1 for 3 cycles during S_C1 -> d stays 1, dv=0 for 3 cycles, sequence resumes with B; total 8 cycles to done.
REQ-030 Bench SHALL check: start with frames=0, and start while busy -> no state change, busy unaffected, no extra frames.
REQ-031 Bench SHALL check: rst pulsed between clock edges in S_B3 -> outputs reach reset values before the next edge, no done; a subsequent start with frames=1 yields a clean 00101.
REQ-032 Bench SHALL check, with PATTERN_GEN_ABORT_EN defined: abort=1 in S_B2 of frame 2 of 4 -> IDLE next cycle, d=1, dv=0, done never asserted.
